div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
//  Initiator/consumer for the serial divider: takes div/rem requests from issue, drives the
//  divider input handshake (one-cycle ready->valid delay) and collects the result. Holds the
//  result until the writeback arbiter grants it. Sits between issue_read_operands and the
//  divider, one instance per divider. Single outstanding operation.
// PARAMETERS
//  WIDTH          64  operand/result width
//  TRANS_ID_BITS  ariane_pkg::TRANS_ID_BITS  transaction id width
// PORTS
//  clk_i          in   1      clock; all state on rising edge
//  rst_ni         in   1      async active-low reset
//  flush_i        in   1      kill in-flight op
//  req_valid_i    in   1      issue request valid
//  req_ready_o    out  1      request accepted when valid&ready
//  req_id_i       in   TRANS_ID_BITS  transaction id
//  req_op_a_i     in   WIDTH  dividend
//  req_op_b_i     in   WIDTH  divisor
//  req_opcode_i   in   2      0 udiv, 1 div, 2 urem, 3 rem
//  div_rdy_i      in   1      divider idle (its in_rdy)
//  div_vld_o      out  1      divider start strobe
//  div_id_o       out  TRANS_ID_BITS  id to divider
//  div_op_a_o     out  WIDTH  operand a to divider
//  div_op_b_o     out  WIDTH  operand b to divider
//  div_opcode_o   out  2      opcode to divider
//  div_flush_o    out  1      flush forwarded to divider
//  div_out_vld_i  in   1      divider result valid
//  div_out_rdy_o  out  1      result accepted
//  div_id_i       in   TRANS_ID_BITS  result id
//  div_res_i      in   WIDTH  result
//  wb_valid_o     out  1      result to writeback valid
//  wb_ready_i     in   1      writeback grant
//  wb_id_o        out  TRANS_ID_BITS  result id
//  wb_result_o    out  WIDTH  result data
//  err_o          out  1      sticky: result id != issued id
// BEHAVIOUR
//  Reset: state IDLE; all regs 0; div_vld_o, div_out_rdy_o, wb_valid_o, err_o = 0.
//  div_flush_o = flush_i (combinational). div_* operand/id/opcode outputs driven from request reg.
//  FSM IDLE -> ISSUE -> BUSY -> HOLD -> IDLE:
//   IDLE : req_ready_o = div_rdy_i & ~flush_i. On accept, capture id/ops/opcode; go to ISSUE.
//   ISSUE: div_vld_o = 1 exactly one cycle; go to BUSY unconditionally.
//   BUSY : div_out_rdy_o = 1. On div_out_vld_i, capture div_res_i/div_id_i; go to HOLD.
//          Set err_o if div_id_i != captured id.
//   HOLD : wb_valid_o = 1; wb_id_o/wb_result_o stable from result reg; on wb_ready_i go to IDLE.
//  req_ready_o = 0 outside IDLE; no new request in the HOLD->IDLE transition cycle.
//  Latency: accept at T, div_vld_o at T+1, wb_valid_o the cycle after divider result handshake.
//  flush_i (any state): state -> IDLE next cycle. Same-cycle div_vld_o, div_out_rdy_o, wb_valid_o
//   and req_ready_o forced 0. A result arriving in the flush cycle is dropped. err_o is unaffected.
//  flush_i and req_valid_i together: request not accepted.
//  err_o cleared only by reset. Reset mid-op: immediate return to IDLE, all outputs to reset values.
// TESTING
//  udiv a=100 b=7 id=3 -> div_vld_o 1 cycle at T+1; wb_valid_o with wb_result_o=14, wb_id_o=3.
//  rem a=-7 b=2 opcode=3 -> wb_result_o=64'hFFFF_FFFF_FFFF_FFFF (-1).
//  wb_ready_i low 5 cycles in HOLD -> wb_valid_o stays high, data stable, req_ready_o=0.
//  flush_i in BUSY -> div_flush_o=1, no wb_valid_o; next request udiv 9/3 -> result 3.
//  Divider returns id 5 for issued id 4 -> err_o=1 and held through subsequent ops until reset.
//  rst_ni low mid-BUSY -> all outputs 0; after release, udiv 8/2 -> result 4.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Sits between the issue stage and one serial divider. It accepts one div/rem
// request, issues it to the divider with a single-cycle start strobe, collects
// the divider result and holds it until the writeback arbiter grants it. Only
// one operation can be in flight.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   flush_i                          kill the in-flight operation
//   req_valid_i / req_ready_o        issue request handshake
//   req_id_i, req_op_a_i,
//   req_op_b_i, req_opcode_i         request payload (opcode: 0 udiv, 1 div,
//                                    2 urem, 3 rem)
//   div_rdy_i                        divider idle
//   div_vld_o                        divider start strobe
//   div_id_o, div_op_a_o,
//   div_op_b_o, div_opcode_o         payload to the divider (request register)
//   div_flush_o                      flush forwarded to the divider
//   div_out_vld_i / div_out_rdy_o    divider result handshake
//   div_id_i, div_res_i              divider result payload
//   wb_valid_o / wb_ready_i          writeback handshake
//   wb_id_o, wb_result_o             writeback payload (result register)
//   err_o                            sticky: divider returned an unexpected id
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    // issue side
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [TRANS_ID_BITS-1:0] req_id_i,
    input  logic [WIDTH-1:0]         req_op_a_i,
    input  logic [WIDTH-1:0]         req_op_b_i,
    input  logic [1:0]               req_opcode_i,
    // divider input side
    input  logic                     div_rdy_i,
    output logic                     div_vld_o,
    output logic [TRANS_ID_BITS-1:0] div_id_o,
    output logic [WIDTH-1:0]         div_op_a_o,
    output logic [WIDTH-1:0]         div_op_b_o,
    output logic [1:0]               div_opcode_o,
    output logic                     div_flush_o,
    // divider output side
    input  logic                     div_out_vld_i,
    output logic                     div_out_rdy_o,
    input  logic [TRANS_ID_BITS-1:0] div_id_i,
    input  logic [WIDTH-1:0]         div_res_i,
    // writeback side
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_id_o,
    output logic [WIDTH-1:0]         wb_result_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e                     state_reg, state_next;

    // Request register: captured on issue acceptance, feeds the divider.
    logic [TRANS_ID_BITS-1:0]   id_reg;
    logic [WIDTH-1:0]           op_a_reg;
    logic [WIDTH-1:0]           op_b_reg;
    logic [1:0]                 opcode_reg;

    // Result register: captured on the divider result handshake.
    logic [TRANS_ID_BITS-1:0]   res_id_reg;
    logic [WIDTH-1:0]           res_reg;

    logic                       err_reg;

    // Capture enables produced by the FSM.
    logic                       req_accept;
    logic                       res_accept;
    logic                       id_mismatch;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        req_ready_o   = 1'b0;
        div_vld_o     = 1'b0;
        div_out_rdy_o = 1'b0;
        wb_valid_o    = 1'b0;
        req_accept    = 1'b0;
        res_accept    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // A flush in the same cycle blocks acceptance so a request
                // that issue is about to kill never reaches the divider.
                req_ready_o = div_rdy_i & ~flush_i;
                if (req_valid_i && req_ready_o) begin
                    req_accept = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                div_vld_o  = ~flush_i;
                state_next = BUSY;
            end
            BUSY: begin
                div_out_rdy_o = ~flush_i;
                if (div_out_vld_i && div_out_rdy_o) begin
                    res_accept = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                wb_valid_o = ~flush_i;
                if (wb_ready_i && wb_valid_o) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Flush wins over every transition; all strobes above are already
        // gated with ~flush_i so nothing leaks out in the flush cycle.
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    assign id_mismatch = res_accept && (div_id_i != id_reg);

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            id_reg     <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            opcode_reg <= '0;
            res_id_reg <= '0;
            res_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (req_accept) begin
                id_reg     <= req_id_i;
                op_a_reg   <= req_op_a_i;
                op_b_reg   <= req_op_b_i;
                opcode_reg <= req_opcode_i;
            end
            if (res_accept) begin
                res_id_reg <= div_id_i;
                res_reg    <= div_res_i;
            end
            // Sticky until reset: a wrong id indicates a protocol bug
            // somewhere upstream, so it must not be lost by later ops.
            if (id_mismatch) begin
                err_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    assign div_flush_o  = flush_i;
    assign div_id_o     = id_reg;
    assign div_op_a_o   = op_a_reg;
    assign div_op_b_o   = op_b_reg;
    assign div_opcode_o = opcode_reg;

    assign wb_id_o      = res_id_reg;
    assign wb_result_o  = res_reg;
    assign err_o        = err_reg;

endmodule
